// File: rtl/score_keeper.sv
// score_keeper: round-robin arbitrated, digit-serial packed-BCD score accumulator.
// Optional high-score register: define SCORE_KEEPER_HIGH_SCORE_EN.
module score_keeper #(
  parameter int NUM_REQ = 4,
  parameter int DIGITS  = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [8*NUM_REQ-1:0]  req_pts,
  output logic [NUM_REQ-1:0]    ack,
  input  logic [1:0]            avs_address,
  input  logic                  avs_chipselect,
  input  logic                  avs_write_n,
  input  logic [31:0]           avs_writedata,
  output logic [31:0]           avs_readdata,
  output logic [4*DIGITS-1:0]   score_out,
  output logic                  busy,
  output logic                  saturated
);

  localparam int SW = 4*DIGITS;
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [SW-1:0] ALL9 = {DIGITS{4'h9}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_DONE
  } state_t;

  function automatic logic [3:0] clamp9(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  state_t          r_state;
  state_t          w_state_nx;
  logic [SW-1:0]   r_score;
  logic [SW-1:0]   r_work;
  logic [7:0]      r_addend;
  logic [IW-1:0]   r_idx;
  logic            r_carry;
  logic            r_sat;
  logic [GW-1:0]   r_last;
  logic [GW-1:0]   r_gnt;

  logic            w_wr;
  logic            w_cpu_score;
  logic [SW-1:0]   w_cpu_val;
  logic            w_found;
  logic [GW-1:0]   w_gnt;
  logic [7:0]      w_pts;
  logic [3:0]      w_wd;
  logic [3:0]      w_ad;
  logic [4:0]      w_s;
  logic [3:0]      w_dig;
  logic            w_c;
  logic            w_lastd;
  logic [SW-1:0]   w_work_nx;
  logic [31:0]     w_hs_rd;
  logic            w_unused;

  assign w_wr = avs_chipselect & ~avs_write_n;

  // Only writes that change the score abort an in-flight add.
  assign w_cpu_score = w_wr &
    ((avs_address == 2'd0) ||
     ((avs_address == 2'd1) && avs_writedata[0]));

  always_comb begin
    w_cpu_val = '0;
    if (avs_address == 2'd0) begin
      for (int d = 0; d < DIGITS; d++) begin
        w_cpu_val[4*d +: 4] = clamp9(avs_writedata[4*d +: 4]);
      end
    end
  end

  always_comb begin
    int j;
    j       = 0;
    w_found = 1'b0;
    w_gnt   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = (int'(r_last) + k) % NUM_REQ;
      if (!w_found && req[j]) begin
        w_found = 1'b1;
        w_gnt   = GW'(j);
      end
    end
  end

  assign w_pts = req_pts[8*int'(w_gnt) +: 8];

  always_comb begin
    unique case (1'b1)
      (r_idx == IW'(0)): w_ad = r_addend[3:0];
      (r_idx == IW'(1)): w_ad = r_addend[7:4];
      default:           w_ad = 4'd0;
    endcase
  end

  assign w_wd = r_work[4*int'(r_idx) +: 4];
  assign w_s  = {1'b0, w_wd} + {1'b0, w_ad} + {4'd0, r_carry};
  assign w_c  = (w_s > 5'd9);
  assign w_dig = w_c ? 4'(w_s - 5'd10) : w_s[3:0];
  assign w_lastd = (r_idx == IW'(DIGITS-1));

  always_comb begin
    w_work_nx = r_work;
    w_work_nx[4*int'(r_idx) +: 4] = w_dig;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE:  if (w_found) w_state_nx = S_ADD;
      S_ADD:   if (w_cpu_score || w_lastd) w_state_nx = S_DONE;
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_score  <= '0;
      r_work   <= '0;
      r_addend <= '0;
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_sat    <= 1'b0;
      r_last   <= GW'(NUM_REQ-1);
      r_gnt    <= '0;
    end else begin
      if (w_cpu_score) begin
        r_score <= w_cpu_val;
        r_sat   <= 1'b0;
      end else if (r_state == S_ADD && w_lastd) begin
        r_score <= w_c ? ALL9 : w_work_nx;
        if (w_c) r_sat <= 1'b1;
      end
      unique case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_addend <= {clamp9(w_pts[7:4]), clamp9(w_pts[3:0])};
            r_work   <= w_cpu_score ? w_cpu_val : r_score;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_last   <= w_gnt;
            r_gnt    <= w_gnt;
          end
        end
        S_ADD: begin
          r_work  <= w_work_nx;
          r_carry <= w_c;
          r_idx   <= r_idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef SCORE_KEEPER_HIGH_SCORE_EN
  logic [SW-1:0] r_high;
  logic          w_hs_clr;

  assign w_hs_clr = w_wr && (avs_address == 2'd2) && avs_writedata[0];

  // Valid packed BCD orders the same as unsigned binary.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)               r_high <= '0;
    else if (w_hs_clr)          r_high <= '0;
    else if (r_score > r_high)  r_high <= r_score;
  end

  assign w_hs_rd = 32'(r_high);
`else
  assign w_hs_rd = 32'd0;
`endif

  always_comb begin
    avs_readdata = 32'd0;
    unique case (avs_address)
      2'd0: avs_readdata = 32'(r_score);
      2'd1: avs_readdata = {30'd0, r_sat, busy};
      2'd2: avs_readdata = w_hs_rd;
      2'd3: avs_readdata = 32'd0;
      default: avs_readdata = 32'd0;
    endcase
  end

  assign ack = (r_state == S_DONE) ?
               (NUM_REQ'(1) << r_gnt) : '0;
  assign busy      = (r_state != S_IDLE);
  assign saturated = r_sat;
  assign score_out = r_score;

  assign w_unused = &{1'b0, avs_writedata[31:SW]};

endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: scoreboard bench for score_keeper.
// Expected acks/scores are queued at drive time and popped on each ack.
module tb_score_keeper;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req;
  logic [31:0] req_pts;
  logic [3:0]  ack;
  logic [1:0]  avs_address;
  logic        avs_chipselect;
  logic        avs_write_n;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic [23:0] score_out;
  logic        busy;
  logic        saturated;

  typedef struct packed {
    logic [3:0]  ack;
    logic [23:0] score;
  } exp_t;

  exp_t        q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [23:0] m;
  int          lat;

  score_keeper dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req            (req),
    .req_pts        (req_pts),
    .ack            (ack),
    .avs_address    (avs_address),
    .avs_chipselect (avs_chipselect),
    .avs_write_n    (avs_write_n),
    .avs_writedata  (avs_writedata),
    .avs_readdata   (avs_readdata),
    .score_out      (score_out),
    .busy           (busy),
    .saturated      (saturated)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] bcd_add(input logic [23:0] s,
                                          input logic [7:0] p);
    int a;
    int hi;
    int lo;
    logic [23:0] r;
    a = 0;
    for (int i = 5; i >= 0; i--) a = a*10 + int'(s[4*i +: 4]);
    hi = (p[7:4] > 4'd9) ? 9 : int'(p[7:4]);
    lo = (p[3:0] > 4'd9) ? 9 : int'(p[3:0]);
    a = a + hi*10 + lo;
    if (a > 999999) a = 999999;
    r = '0;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(a % 10);
      a = a / 10;
    end
    return r;
  endfunction

  task automatic push(input int i, input logic [23:0] sc);
    exp_t e;
    e.ack   = 4'(1 << i);
    e.score = sc;
    q.push_back(e);
  endtask

  task automatic cpu_wr(input logic [1:0] a, input logic [31:0] d);
    avs_address    = a;
    avs_writedata  = d;
    avs_chipselect = 1'b1;
    avs_write_n    = 1'b0;
    tick();
    avs_chipselect = 1'b0;
    avs_write_n    = 1'b1;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a,
                        input logic [31:0] exp);
    avs_address = a;
    #1;
    chk(tag, avs_readdata, exp);
  endtask

  task automatic wait_acks(input int n, output int l);
    int   got;
    exp_t e;
    got = 0;
    l   = -1;
    for (int c = 0; c < 64 && got < n; c++) begin
      if (ack != 4'd0) begin
        if (q.size() == 0) begin
          chk("unexpected_ack", 32'(ack), 32'd0);
        end else begin
          e = q.pop_front();
          chk("ack", 32'(ack), 32'(e.ack));
          chk("score", 32'(score_out), 32'(e.score));
        end
        if (got == 0) l = c;
        got++;
        req = req & ~ack;
      end
      tick();
    end
    if (got < n) chk("ack_timeout", 32'(got), 32'(n));
  endtask

  task automatic add_one(input int i, input logic [7:0] p);
    int l;
    req_pts[8*i +: 8] = p;
    req[i] = 1'b1;
    m = bcd_add(m, p);
    push(i, m);
    wait_acks(1, l);
    chk("latency", 32'(l), 32'd7);
    chk("busy_after", 32'(busy), 32'd0);
  endtask

  initial begin
    reset_n        = 1'b0;
    req            = '0;
    req_pts        = '0;
    avs_address    = '0;
    avs_chipselect = 1'b0;
    avs_write_n    = 1'b1;
    avs_writedata  = '0;
    repeat (2) tick();
    chk("rst_score", 32'(score_out), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sat", 32'(saturated), 32'd0);
    reset_n = 1'b1;
    tick();

    cpu_wr(2'd0, 32'h777);
    rd_chk("rd_set", 2'd0, 32'h777);
    req_pts[7:0] = 8'h25;
    req[0] = 1'b1;
    repeat (3) tick();
    chk("busy_mid", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mrst_score", 32'(score_out), 32'd0);
    chk("mrst_ack", 32'(ack), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    for (int a = 0; a < 4; a++) rd_chk("mrst_rd", 2'(a), 32'd0);
    req = '0;
    tick();
    reset_n = 1'b1;
    tick();

    cpu_wr(2'd0, 32'h95);
    m = 24'h95;
    add_one(0, 8'h25);
    chk("single", 32'(score_out), 32'h120);

    req_pts[15:8]  = 8'h01;
    req_pts[23:16] = 8'h01;
    m = bcd_add(m, 8'h01); push(1, m);
    m = bcd_add(m, 8'h01); push(2, m);
    req[1] = 1'b1;
    req[2] = 1'b1;
    wait_acks(2, lat);

    req_pts[7:0]  = 8'h01;
    req_pts[15:8] = 8'h01;
    m = bcd_add(m, 8'h01); push(0, m);
    m = bcd_add(m, 8'h01); push(1, m);
    req[0] = 1'b1;
    req[1] = 1'b1;
    wait_acks(2, lat);
    rd_chk("rr_score", 2'd0, 32'h124);

    cpu_wr(2'd0, 32'h999990);
    m = 24'h999990;
    add_one(0, 8'h15);
    rd_chk("sat_st", 2'd1, 32'h2);
    add_one(3, 8'h01);
    chk("sat_hold", 32'(score_out), 32'h999999);

    req_pts[7:0] = 8'h11;
    req[0] = 1'b1;
    push(0, 24'h009912);
    repeat (3) tick();
    cpu_wr(2'd0, 32'h00AB12);
    wait_acks(1, lat);
    m = 24'h009912;
    rd_chk("ovr_st", 2'd1, 32'h0);
    rd_chk("ovr_score", 2'd0, 32'h009912);

    cpu_wr(2'd0, 32'h100);
    m = 24'h100;
    add_one(1, 8'hA3);
    chk("clamp", 32'(score_out), 32'h193);
    add_one(2, 8'h00);
    cpu_wr(2'd0, 32'h099999);
    m = 24'h099999;
    add_one(3, 8'h01);
    chk("ripple", 32'(score_out), 32'h100000);

    cpu_wr(2'd3, 32'h123);
    rd_chk("a3_nowr", 2'd0, 32'h100000);
    rd_chk("a3_rd", 2'd3, 32'h0);

`ifdef SCORE_KEEPER_HIGH_SCORE_EN
    cpu_wr(2'd1, 32'h1);
    cpu_wr(2'd2, 32'h1);
    tick();
    rd_chk("hs_clr", 2'd2, 32'h0);
    cpu_wr(2'd0, 32'h450);
    m = 24'h450;
    add_one(0, 8'h50);
    cpu_wr(2'd1, 32'h1);
    tick();
    rd_chk("hs_score0", 2'd0, 32'h0);
    rd_chk("hs_keep", 2'd2, 32'h500);
`else
    cpu_wr(2'd2, 32'h1);
    rd_chk("hs_off", 2'd2, 32'h0);
    cpu_wr(2'd1, 32'h1);
    rd_chk("clr_score", 2'd0, 32'h0);
`endif

    chk("q_empty", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
Hardware score accumulator and arbiter. It owns the 6-digit packed-BCD score shown on the HEX displays. Several game-logic event sources request point additions; the block arbitrates between them round-robin and adds digit-serially. The NIOS CPU reads, sets and clears the score through a 4-word Avalon-MM slave.

Parameters:
NUM_REQ, 4, number of hardware point requesters (2..8)
DIGITS, 6, BCD digits in score; score width = 4*DIGITS

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
req  in  NUM_REQ  per-requester add request, level, held until ack
req_pts  in  8*NUM_REQ  per-requester 2-digit BCD points, slice i = bits [8i+7:8i], stable while req[i]
ack  out  NUM_REQ  one-cycle completion pulse, one-hot
avs_address  in  2  word address
avs_chipselect  in  1  slave select
avs_write_n  in  1  active-low write strobe
avs_writedata  in  32  write data
avs_readdata  out  32  read data, combinational from address
score_out  out  4*DIGITS  committed score, packed BCD, to display driver
busy  out  1  FSM not in IDLE
saturated  out  1  score clamped at all-9s

Behaviour:
- Clock clk; reset reset_n, asynchronous, active-low.
- Reset: score_out=0, work=0, ack=0, busy=0, saturated=0, FSM=IDLE, last_grant=NUM_REQ-1.
- FSM states: IDLE, ADD, DONE.
- IDLE:
  - If any req bit is set, grant the first set bit searching from last_grant+1, wrapping modulo NUM_REQ.
  - Latch that requester's req_pts into addend; load work from score_out; set digit index=0, carry=0; update last_grant; go to ADD.
- ADD (DIGITS cycles):
  - Each cycle, s = work digit[idx] + addend digit[idx] + carry. Addend digits >=2 are 0; any addend digit >9 is treated as 9.
  - If s>9: digit=s-10, carry=1; else digit=s, carry=0. Then idx++.
  - After digit DIGITS-1: if carry=1, work is forced to all 9s and saturated is set. Go to DONE.
- DONE (1 cycle):
  - ack[grant]=1 for this cycle only; score_out<=work on entry; go to IDLE.
- Latency: req sampled in IDLE cycle T; ack high in cycle T+DIGITS+1; next grant is possible at T+DIGITS+2.
- Requester protocol:
  - req[i] may drop only after ack[i] is seen.
  - Dropping req mid-operation does not abort the add.
  - req_pts=0x00 still runs the full sequence and returns an ack.
- Saturated state: further adds complete normally with ack; the score stays all 9s.
- Register map (write = chipselect & ~write_n):
  - addr0 read: {zero-extend, score_out}.
  - addr0 write: score_out<=writedata[4*DIGITS-1:0], with each nibble >9 clamped to 9; clears saturated.
  - addr1 read: {30'b0, saturated, busy}.
  - addr1 write: bit0=1 clears score_out and saturated.
  - addr2: see Optional Feature.
  - addr3 reads 0; writes to addr3 are ignored.
- CPU write during ADD: the CPU write wins. The FSM jumps to DONE next cycle and issues ack to the current grantee, but the in-flight points are discarded and score_out keeps the CPU value.
- CPU write in DONE cycle: the CPU value overrides the work commit.
- Reset mid-operation: all state returns to reset values immediately; no ack is issued.

Optional Feature:
- Macro: SCORE_KEEPER_HIGH_SCORE_EN.
- Defined:
  - Register high_score (4*DIGITS bits, reset 0) updates to score_out whenever the committed score exceeds it. BCD compare is numeric, most significant digit first.
  - addr2 read returns high_score.
  - addr2 write with bit0=1 clears high_score.
  - CPU clear/set of the score does not lower high_score.
- Undefined: no register is built, addr2 reads 0, and addr2 writes are ignored.

Test Plan:
- Reset: assert reset_n=0 mid-ADD -> score_out=0, ack=0, busy=0, avs_readdata=0 at every address.
- Single add: score 000095, req[0] with pts 0x25 -> ack[0] exactly 7 cycles after sampling, score_out=000120, busy low after.
- Round-robin: req[1] and req[2] together, pts 0x01 each -> ack[1] then ack[2], score +2; then req[0] and req[1] with last_grant=2 -> req[0] served first.
- Saturation: score 999990 + 0x15 -> score_out=999999, addr1 reads 0x2; another add of 0x01 -> ack issued, score stays 999999.
- CPU override: write addr0 0x00AB12 during ADD -> score_out=009912, grantee still acked, points dropped, saturated=0.
- High score: with macro, reach 000500, clear via addr1 -> addr2 reads 0x500; without macro addr2 reads 0.
